rf_scan_controller: RTL
=======================

Name: rf_scan_controller

Overview:
- Sequences the receptive-field selector and the bank of parallel convolution units across one feature map.
- Walks output rows and column groups, drives `row`/`column` into the selector and starts the conv bank.
- Waits for conv completion, then hands each result group downstream with a valid/ready handshake.
- Sits between the layer-level control FSM and the selector/conv datapath of each conv layer.

Parameters:
- H, 32, input image height
- W, 32, input image width
- Size, 5, filter size
- NUM_UNITS, 14, parallel conv units; output pixels produced per pass

Derived: OH = H-Size+1 and OW = W-Size+1 (output height and width); NPASS = OH * ceil(OW/NUM_UNITS).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a full-map scan
- row  out  8  output row index driven to the selector
- column  out  8  first output column of the current group, driven to the selector
- conv_start  out  1  one-cycle pulse to start the conv bank
- conv_done  in  1  conv bank finished the current group
- out_valid  out  1  result group available
- out_ready  in  1  downstream accepts the group
- out_row  out  8  row of the presented group
- out_col  out  8  first column of the presented group
- out_count  out  8  valid lanes in the group: min(NUM_UNITS, OW-out_col)
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse after the last group is accepted

Behaviour:
- Reset, asynchronous while reset_n=0: state=IDLE; row, column, out_row, out_col, out_count = 0; conv_start, out_valid, busy, done = 0.
- Reset asserted mid-scan aborts immediately; no done pulse is issued.
- IDLE:
  - busy=0.
  - start=1 loads row=0, column=0, sets busy=1 and goes to ISSUE.
- ISSUE (exactly 1 cycle):
  - conv_start=1; row/column held stable.
  - Next state is WAIT_CONV.
- WAIT_CONV:
  - conv_done is sampled only in this state; conv_done during ISSUE is ignored.
  - On conv_done=1: latch out_row=row, out_col=column, out_count=min(NUM_UNITS, OW-column); go to OUTPUT.
  - Minimum conv_start to out_valid latency is 2 cycles (conv_done high in the first WAIT_CONV cycle).
- OUTPUT:
  - out_valid=1; out_row, out_col and out_count held stable until the handshake completes.
  - Transfer occurs on a cycle with out_valid=1 and out_ready=1. On transfer, advance and leave OUTPUT in the same edge:
    - if column+NUM_UNITS < OW: column += NUM_UNITS, go to ISSUE;
    - else if row < OH-1: column=0, row += 1, go to ISSUE;
    - else go to FINISH.
  - out_ready=0 stalls indefinitely; no new conv_start is issued during the stall.
- FINISH (1 cycle):
  - done=1, busy=0 on the following cycle; go to IDLE.
  - row/column return to 0.
- start while busy=1 is ignored, including start in the FINISH cycle.
- start in IDLE in the cycle right after FINISH is accepted.
- row/column change only on a transfer edge or on start, so the selector output is stable from ISSUE through OUTPUT.
- Arithmetic:
  - Column compare uses 9-bit unsigned arithmetic to avoid wrap when column+NUM_UNITS > 255.
  - out_count = OW-column when that is < NUM_UNITS, else NUM_UNITS.
- Elaboration requirements: Size ≤ H, Size ≤ W, W ≤ 256, H ≤ 256, 1 ≤ NUM_UNITS ≤ OW. Otherwise elaboration fails via an assertion.
- Exactly NPASS conv_start pulses and NPASS transfers occur per scan.

Test Plan:
- H=W=8, Size=5, NUM_UNITS=3, conv_done 1 cycle after ISSUE, out_ready=1 → 8 groups, (row,col,count) = (0,0,3),(0,3,1),(1,0,3)…(3,3,1); one done pulse; busy low afterwards.
- Default parameters (32/32/5/14), out_ready=1 → 56 conv_start pulses; groups (r,0,14),(r,14,14) for r = 0..27; last group (27,14,14), then done.
- Hold out_ready=0 for 10 cycles on group (1,3) in the 8/8/5/3 config → out_valid and (1,3,1) stable throughout; no conv_start; advance to (2,0) one cycle after out_ready rises.
- Pulse start during WAIT_CONV and during FINISH → ignored; group sequence unchanged.
- Assert reset_n=0 mid-scan in OUTPUT → all outputs 0 asynchronously and no done pulse; then start → scan restarts at (0,0).
- conv_done held high continuously, and conv_done pulsed during ISSUE only → first case gives 2-cycle issue-to-valid; second case stays in WAIT_CONV until a fresh conv_done arrives.

Source files
------------

// File: rtl/rf_scan_controller.sv
// rf_scan_controller
// Walks every output row and every column group of one feature map.
// For each group it presents row/column to the receptive-field selector,
// pulses conv_start, and waits for conv_done. It then holds the result group
// on a valid/ready interface until downstream accepts it.
// A full scan issues OH * ceil(OW/NUM_UNITS) groups and then ends with a
// single done pulse.

module rf_scan_controller #(
  parameter int H         = 32,
  parameter int W         = 32,
  parameter int Size      = 5,
  parameter int NUM_UNITS = 14
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [7:0] row,
  output logic [7:0] column,
  output logic       conv_start,
  input  logic       conv_done,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_row,
  output logic [7:0] out_col,
  output logic [7:0] out_count,
  output logic       busy,
  output logic       done
);

  // Output map geometry
  localparam int OH = H - Size + 1;
  localparam int OW = W - Size + 1;

  // 9-bit copies of the constants. Column arithmetic runs at this width so
  // that column + NUM_UNITS cannot wrap when the map is up to 256 wide.
  localparam logic [8:0] OW9       = 9'(OW);
  localparam logic [8:0] LAST_ROW9 = 9'(OH - 1);
  localparam logic [8:0] NU9       = 9'(NUM_UNITS);

  // Reject geometries that the 8-bit row/column ports cannot represent, and
  // unit counts that cannot tile the output width.
  if (Size > H || Size > W || H > 256 || W > 256 ||
      NUM_UNITS < 1 || NUM_UNITS > OW) begin : g_bad_params
    $error("rf_scan_controller: illegal parameters H=%0d W=%0d Size=%0d NUM_UNITS=%0d",
           H, W, Size, NUM_UNITS);
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CONV,
    OUTPUT,
    FINISH
  } state_t;

  state_t state;
  state_t state_next;

  // Datapath decisions, all at 9 bits
  logic [8:0] col_next9;
  logic [8:0] remain9;
  logic       more_cols;
  logic       more_rows;
  logic       accept_start;
  logic       take_result;
  logic       xfer;

  assign col_next9    = {1'b0, column} + NU9;
  assign remain9      = OW9 - {1'b0, column};
  assign more_cols    = (col_next9 < OW9);
  assign more_rows    = ({1'b0, row} < LAST_ROW9);
  assign accept_start = (state == IDLE) && start;
  assign take_result  = (state == WAIT_CONV) && conv_done;
  assign xfer         = (state == OUTPUT) && out_ready;

  // State register
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the state-decoded control outputs
  // NOTE: every signal assigned here gets a default value first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    conv_start = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // conv_done is deliberately not looked at here
        conv_start = 1'b1;
        state_next = WAIT_CONV;
      end
      WAIT_CONV: begin
        if (conv_done) begin
          state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = (more_cols || more_rows) ? ISSUE : FINISH;
        end
      end
      FINISH: begin
        // start is ignored here; a new scan can begin in the following IDLE
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Scan position. It moves only on start or on an accepted transfer, so the
  // selector sees a stable position from ISSUE through OUTPUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row    <= '0;
      column <= '0;
    end else if (accept_start) begin
      row    <= '0;
      column <= '0;
    end else if (xfer) begin
      if (more_cols) begin
        column <= col_next9[7:0];
      end else if (more_rows) begin
        column <= '0;
        row    <= row + 8'd1;
      end else begin
        // Last group accepted; return to the origin for the next scan
        column <= '0;
        row    <= '0;
      end
    end
  end

  // Result descriptor, captured on conv completion and held through OUTPUT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_row   <= '0;
      out_col   <= '0;
      out_count <= '0;
    end else if (take_result) begin
      out_row   <= row;
      out_col   <= column;
      // The final group of a row may have fewer lanes than NUM_UNITS
      out_count <= (remain9 < NU9) ? remain9[7:0] : NU9[7:0];
    end
  end

endmodule
